// File: rtl/miner_search_ctrl.sv
// Nonce search controller: issues sequential nonces to the hash pipeline, compares returned
// digests against the captured difficulty and latches the first winning nonce.
module miner_search_ctrl #(
    parameter int unsigned INFLIGHT_W  = 6,
    parameter logic [63:0] TEST_OFFSET = 64'd16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_async,
    input  logic         test_async,
    input  logic [63:0]  start_nonce,
    input  logic [255:0] difficulty,
    output logic         msg_valid,
    input  logic         msg_ready,
    output logic [63:0]  msg_nonce,
    input  logic         hash_valid,
    input  logic [255:0] hash,
    input  logic [63:0]  hash_nonce,
    output logic [63:0]  solution,
    output logic [2:0]   status,
    output logic         irq,
    output logic [1:0]   state_dbg
);

    // Handshake: a nonce moves to the pipeline on a cycle where msg_valid && msg_ready;
    // msg_valid never depends on msg_ready, and hash_valid is a strobe with no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FOUND = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            run_sync_q, test_sync_q;
    logic                  run_prev_q;
    logic [63:0]           nonce_q, nonce_d;
    logic [63:0]           base_q, base_d;
    logic [63:0]           sol_q, sol_d;
    logic [255:0]          diff_q, diff_d;
    logic                  test_q, test_d;
    logic                  found_q, found_d;
    logic                  cmp_vld_q, match_q;
    logic [63:0]           cmp_nonce_q;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;

    logic run_s, test_s, run_rise, xfer, hash_hit;

    assign run_s    = run_sync_q[1];
    assign test_s   = test_sync_q[1];
    assign run_rise = run_s && !run_prev_q;

    // A compare result suppresses issue in the same cycle so nothing new launches once a winner exists.
    assign msg_valid = (state_q == RUN) && !match_q;
    assign xfer      = msg_valid && msg_ready;
    assign hash_hit  = (hash < diff_q) || (test_q && (hash_nonce == base_q + TEST_OFFSET));

    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, hash_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        nonce_d = xfer ? nonce_q + 64'd1 : nonce_q;
        base_d  = base_q;
        diff_d  = diff_q;
        test_d  = test_q;
        found_d = found_q;
        sol_d   = sol_q;
        case (state_q)
            IDLE: begin
                if (run_rise) begin
                    state_d = RUN;
                    nonce_d = start_nonce;
                    base_d  = start_nonce;
                    diff_d  = difficulty;
                    test_d  = test_s;
                    found_d = 1'b0;
                    sol_d   = '0;
                end
            end
            RUN: begin
                if (match_q) begin
                    state_d = FOUND;
                    found_d = 1'b1;
                    sol_d   = cmp_nonce_q;
                end else if (!run_s) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (match_q) begin
                    state_d = FOUND;
                    found_d = 1'b1;
                    sol_d   = cmp_nonce_q;
                end else if (inflight_q == '0 && !cmp_vld_q) begin
                    state_d = IDLE;
                end
            end
            FOUND: begin
                if (!run_s && inflight_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            run_sync_q  <= '0;
            test_sync_q <= '0;
            run_prev_q  <= 1'b0;
            nonce_q     <= '0;
            base_q      <= '0;
            sol_q       <= '0;
            diff_q      <= '0;
            test_q      <= 1'b0;
            found_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            match_q     <= 1'b0;
            cmp_nonce_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_sync_q  <= {run_sync_q[0], run_async};
            test_sync_q <= {test_sync_q[0], test_async};
            run_prev_q  <= run_s;
            nonce_q     <= nonce_d;
            base_q      <= base_d;
            sol_q       <= sol_d;
            diff_q      <= diff_d;
            test_q      <= test_d;
            found_q     <= found_d;
            cmp_vld_q   <= hash_valid;
            match_q     <= hash_valid && hash_hit;
            cmp_nonce_q <= hash_nonce;
            inflight_q  <= inflight_d;
        end
    end

    assign msg_nonce = nonce_q;
    assign solution  = sol_q;
    assign irq       = found_q;
    assign status    = {test_q && (state_q != IDLE), state_q == RUN, found_q};
    assign state_dbg = state_q;

endmodule

// File: tb/tb_miner_search_ctrl.sv
// Bench for miner_search_ctrl: fixed-depth pipeline model, nonce scoreboard and a first-match
// reference model, driven by a vector table, corner-case sequences and randomized searches.
module tb_miner_search_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FOUND = 2'd3;

    logic         clk = 1'b0;
    logic         rst, run_async, test_async;
    logic [63:0]  start_nonce;
    logic [255:0] difficulty;
    logic         msg_valid, msg_ready;
    logic [63:0]  msg_nonce;
    logic         hash_valid;
    logic [255:0] hash;
    logic [63:0]  hash_nonce;
    logic [63:0]  solution;
    logic [2:0]   status;
    logic         irq;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    miner_search_ctrl dut (
        .clk(clk), .rst(rst), .run_async(run_async), .test_async(test_async),
        .start_nonce(start_nonce), .difficulty(difficulty),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_nonce(msg_nonce),
        .hash_valid(hash_valid), .hash(hash), .hash_nonce(hash_nonce),
        .solution(solution), .status(status), .irq(irq), .state_dbg(state_dbg)
    );

    typedef struct {
        logic [63:0]  nonce;
        logic [255:0] h;
        int           due;
    } pl_t;

    typedef struct {
        logic [63:0]  start;
        logic [255:0] diff;
        logic         test;
        int           rpct;
        logic [63:0]  exp_sol;
        logic [2:0]   exp_status;
    } vec_t;

    pl_t          pipe_q[$];
    logic [63:0]  exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           depth = 24;
    int           ready_pct = 100;
    int           hit_pct = 0;
    int           n_xfer = 0;

    logic [255:0] m_diff;
    logic [63:0]  m_base, m_sol;
    logic         m_test;
    bit           m_found;
    int           m_match_cyc;
    bit           chk_found = 0;

    logic         obs_valid, obs_irq;
    logic [63:0]  obs_nonce, obs_sol;
    logic [2:0]   obs_status;
    logic [1:0]   obs_state, prev_state = S_IDLE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] gen_hash();
        logic [255:0] r;
        r = rand256();
        if ($urandom_range(99) < hit_pct) r[255:224] = '0;
        return r;
    endfunction

    // One clock: observe at the falling edge, score, then drive inputs for the next rising edge.
    task automatic step();
        pl_t         e;
        bit          xfer;
        bit          exp_found;
        logic [63:0] nxt;
        @(negedge clk);
        obs_valid  = msg_valid;
        obs_nonce  = msg_nonce;
        obs_sol    = solution;
        obs_status = status;
        obs_irq    = irq;
        obs_state  = state_dbg;
        if ((prev_state == S_DRAIN || prev_state == S_FOUND) && obs_state == S_IDLE)
            check("idle_with_empty_pipe", pipe_q.size(), 0);
        prev_state = obs_state;
        if (chk_found) begin
            exp_found = m_found && (cyc >= m_match_cyc + 2);
            check("found", obs_status[0], exp_found);
            check("irq", obs_irq, exp_found);
            if (exp_found) check("solution", obs_sol, m_sol);
        end
        if (obs_status[0]) check("no_issue_after_found", obs_valid, 0);

        msg_ready  = ($urandom_range(99) < ready_pct);
        xfer       = obs_valid && msg_ready;
        hash_valid = 1'b0;
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            e          = pipe_q.pop_front();
            hash_valid = 1'b1;
            hash       = e.h;
            hash_nonce = e.nonce;
            if (!m_found && (e.h < m_diff || (m_test && e.nonce == m_base + 64'd16))) begin
                m_found     = 1'b1;
                m_match_cyc = cyc;
                m_sol       = e.nonce;
            end
        end
        if (xfer) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                nxt = exp_q.pop_front();
                check("nonce_order", obs_nonce, nxt);
                exp_q.push_back(nxt + 64'd1);
            end
            e.nonce = obs_nonce;
            e.h     = gen_hash();
            e.due   = cyc + depth;
            pipe_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic start_run(input logic [63:0] s, input logic [255:0] d, input logic t);
        int n;
        m_base    = s;
        m_diff    = d;
        m_test    = t;
        m_found   = 1'b0;
        chk_found = 1'b0;
        exp_q.delete();
        exp_q.push_back(s);
        start_nonce = s;
        difficulty  = d;
        test_async  = t;
        run_async   = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_valid && n < 10);
        check("start_latency", n, 3);
        chk_found = 1'b1;
    endtask

    task automatic stop_run();
        int n;
        run_async = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (obs_state != S_IDLE && n < 600);
        check("reach_idle", obs_state, S_IDLE);
    endtask

    task automatic wait_found(input int budget);
        int n;
        n = 0;
        while (!obs_status[0] && n < budget) begin
            step();
            n++;
        end
    endtask

    vec_t vecs[4];

    initial begin
        int          n;
        int          x0;
        logic [255:0] d;

        vecs[0] = '{64'h10,                  {256{1'b1}}, 1'b0, 100, 64'h10,   3'b001};
        vecs[1] = '{64'h100,                 256'd0,      1'b1, 100, 64'h110,  3'b101};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 256'd0,      1'b1, 100, 64'h0E,   3'b101};
        vecs[3] = '{64'h5000,                256'd0,      1'b1, 50,  64'h5010, 3'b101};

        rst = 1'b1; run_async = 1'b0; test_async = 1'b0;
        start_nonce = '0; difficulty = '0; msg_ready = 1'b0;
        hash_valid = 1'b0; hash = '0; hash_nonce = '0;
        m_diff = '0; m_base = '0; m_sol = '0; m_test = 1'b0; m_found = 1'b0; m_match_cyc = 0;
        repeat (3) step();
        check("rst_msg_valid", obs_valid, 0);
        check("rst_msg_nonce", obs_nonce, 0);
        check("rst_solution", obs_sol, 0);
        check("rst_status", obs_status, 0);
        check("rst_irq", obs_irq, 0);
        check("rst_state", obs_state, S_IDLE);
        rst = 1'b0;
        step();

        depth = 24;
        hit_pct = 0;
        for (int i = 0; i < 4; i++) begin
            ready_pct = vecs[i].rpct;
            start_run(vecs[i].start, vecs[i].diff, vecs[i].test);
            wait_found(400);
            repeat (30) step();
            check("vec_solution", obs_sol, vecs[i].exp_sol);
            check("vec_status", obs_status, vecs[i].exp_status);
            check("vec_irq", obs_irq, 1);
            stop_run();
            check("idle_status_holds_found", obs_status, 3'b001);
            check("idle_solution_holds", obs_sol, vecs[i].exp_sol);
        end

        // Drop run with no solution: one more issue cycle, then DRAIN, then IDLE once empty.
        ready_pct = 100;
        start_run(64'h2000, 256'd0, 1'b0);
        repeat (100) step();
        run_async = 1'b0;
        step();
        step();
        check("running_before_fall_seen", obs_status[1], 1);
        step();
        check("running_after_drop", obs_status[1], 0);
        check("msg_valid_in_drain", obs_valid, 0);
        check("state_drain", obs_state, S_DRAIN);
        stop_run();
        check("drop_status", obs_status, 0);
        check("drop_irq", obs_irq, 0);

        // Reset in the middle of a search with ten nonces outstanding.
        start_run(64'h3000, 256'd0, 1'b0);
        n = 0;
        while (pipe_q.size() < 10 && n < 100) begin
            step();
            n++;
        end
        check("ten_in_flight", pipe_q.size() >= 10, 1);
        rst = 1'b1;
        pipe_q.delete();
        exp_q.delete();
        exp_q.push_back(64'h3000);
        m_found = 1'b0;
        step();
        check("midrst_msg_valid", obs_valid, 0);
        check("midrst_status", obs_status, 0);
        check("midrst_irq", obs_irq, 0);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_valid && n < 10);
        check("restart_latency", n, 3);
        check("restart_nonce", obs_nonce, 64'h3000);
        x0 = n_xfer;
        repeat (20) step();
        check("restart_issues", (n_xfer - x0) > 0, 1);
        stop_run();

        // Randomized searches against the first-match reference model.
        for (int r = 0; r < 6; r++) begin
            depth     = $urandom_range(1, 40);
            ready_pct = $urandom_range(30, 100);
            hit_pct   = 4;
            d         = rand256();
            d[255:244] = '0;
            start_run({$urandom(), $urandom()}, d, 1'($urandom_range(1)));
            wait_found(1500);
            repeat (depth + 5) step();
            stop_run();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
